// File: rtl/pkg_word_uart_tx_pkg.sv
// Shared UART definitions for the telemetry word transmitter.
// FSM state encoding is fixed. PARITY keeps its code even when parity is disabled.
package pkg_word_uart_tx_pkg;

    localparam int unsigned UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Ceiling log2, used to size counters at elaboration time.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pkg_word_uart_tx_baud_tick.sv
// Baud counter: one-cycle tick every CLKS_PER_BIT cycles, cleared while i_clr is high.
module uart_baud_tick
    import pkg_word_uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick_c
);

    localparam int unsigned CNT_W = (clog2(CLKS_PER_BIT) == 0) ? 1 : clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign o_tick_c = (r_cnt == CNT_LAST) && !i_clr;

endmodule

// File: rtl/pkg_word_uart_tx.sv
// Serialises one 32-bit word as NUM_BYTES UART bytes, MSB byte first, LSB bit first.
// Optional even parity bit per byte when PKG_UART_PARITY_EN is defined.
module pkg_word_uart_tx
    import pkg_word_uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50_000_000,
    parameter int unsigned BAUD_RATE   = 115_200,
    parameter int unsigned NUM_BYTES   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_tx_start,
    input  logic [32:0] i_tx_data,
    input  logic        i_tx_data_vld,
    output logic        o_tx_busy,
    output logic        o_tx_done,
    output logic        o_tx_drop,
    output logic        o_txd
);

    localparam int unsigned CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
    localparam int unsigned WORD_W       = NUM_BYTES * UART_DATA_BITS;
    localparam int unsigned BYTE_CNT_W   = (clog2(NUM_BYTES) == 0) ? 1 : clog2(NUM_BYTES);
    localparam int unsigned BIT_CNT_W    = clog2(UART_DATA_BITS);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(UART_DATA_BITS - 1);

    state_t                        r_state, w_state_nxt;
    logic [WORD_W-1:0]             r_shreg, w_shreg_nxt;
    logic [UART_DATA_BITS-1:0]     r_byte, w_byte_nxt;
    logic [BIT_CNT_W-1:0]          r_bit_cnt, w_bit_cnt_nxt;
    logic [BYTE_CNT_W-1:0]         r_byte_cnt, w_byte_cnt_nxt;
    logic                          r_txd, w_txd_nxt;
    logic                          r_busy, w_busy_nxt;
    logic                          r_done, w_done_nxt;
    logic                          r_drop, w_drop_nxt;
    logic                          w_tick;
    logic                          w_fire;
    logic                          w_unused_data;

    assign w_fire        = i_tx_start & i_tx_data_vld;
    assign w_unused_data = ^i_tx_data[32:WORD_W];

    uart_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (r_state == ST_IDLE),
        .o_tick_c (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_byte     <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_txd      <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_byte     <= w_byte_nxt;
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_byte_cnt <= w_byte_cnt_nxt;
            r_txd      <= w_txd_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_drop     <= w_drop_nxt;
        end
    end

    // Next-state and next-output logic; r_txd always carries the level of the bit in progress.
    always_comb begin
        w_state_nxt    = r_state;
        w_shreg_nxt    = r_shreg;
        w_byte_nxt     = r_byte;
        w_bit_cnt_nxt  = r_bit_cnt;
        w_byte_cnt_nxt = r_byte_cnt;
        w_txd_nxt      = r_txd;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_drop_nxt     = w_fire && (r_state != ST_IDLE);

        case (r_state)
            ST_IDLE: begin
                if (w_fire) begin
                    w_state_nxt    = ST_START;
                    w_shreg_nxt    = i_tx_data[WORD_W-1:0];
                    w_byte_cnt_nxt = BYTE_CNT_W'(NUM_BYTES - 1);
                    w_busy_nxt     = 1'b1;
                    w_txd_nxt      = 1'b0;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt   = ST_DATA;
                    w_byte_nxt    = r_shreg[WORD_W-1 -: UART_DATA_BITS];
                    w_shreg_nxt   = r_shreg << UART_DATA_BITS;
                    w_bit_cnt_nxt = '0;
                    w_txd_nxt     = r_shreg[WORD_W-UART_DATA_BITS];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_cnt == BIT_LAST) begin
`ifdef PKG_UART_PARITY_EN
                        w_state_nxt = ST_PARITY;
                        w_txd_nxt   = ^r_byte;
`else
                        w_state_nxt = ST_STOP;
                        w_txd_nxt   = 1'b1;
`endif
                    end else begin
                        w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
                        w_txd_nxt     = r_byte[w_bit_cnt_nxt];
                    end
                end
            end
            ST_PARITY: begin
                if (w_tick) begin
                    w_state_nxt = ST_STOP;
                    w_txd_nxt   = 1'b1;
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (r_byte_cnt != '0) begin
                        w_state_nxt    = ST_START;
                        w_byte_cnt_nxt = r_byte_cnt - BYTE_CNT_W'(1);
                        w_txd_nxt      = 1'b0;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_txd_nxt   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
                w_txd_nxt   = 1'b1;
            end
        endcase
    end

    assign o_txd     = r_txd;
    assign o_tx_busy = r_busy;
    assign o_tx_done = r_done;
    assign o_tx_drop = r_drop;

endmodule
